// File: rtl/lsu_ctrl_if.sv
// Memory bus between the LSU and the data memory: one request channel
// (valid/ready) and a response channel that only carries load data.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid;
  logic [63:0] resp_rdata;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: takes one EX-stage instruction at a time, issues
// a dword-aligned bus request for memory ops and hands the result to WB.
module lsu_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [1:0]  mem_size,
  input  logic        mem_ext_un,
  input  logic [63:0] alu_result,
  input  logic [63:0] store_data,
  input  logic        rd_wena_i,
  input  logic        exception_i,
  lsu_ctrl_if.master  bus,
  output logic        wb_valid,
  output logic [63:0] wb_alu_result,
  output logic [63:0] wb_mem_data,
  output logic [7:0]  wb_byte_enable,
  output logic        wb_mem_to_reg,
  output logic        wb_mem_ext_un,
  output logic        wb_rd_wena,
  output logic        wb_exception,
  output logic        stall,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  typedef struct packed {
    logic        valid;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } req_t;

  typedef struct packed {
    logic        is_load;
    logic [1:0]  size;
    logic        ext_un;
    logic [63:0] addr;
    logic        rd_wena;
  } ctx_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] alu_result;
    logic [63:0] mem_data;
    logic [7:0]  byte_enable;
    logic        mem_to_reg;
    logic        mem_ext_un;
    logic        rd_wena;
    logic        exception;
    logic        misalign;
  } wb_t;

  function automatic logic [7:0] size_mask(input logic [1:0] s);
    case (s)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  ctx_t        ctx_q, ctx_d;
  wb_t         wb_q, wb_d;
  logic [63:0] rdata_q, rdata_d;

  logic [2:0]  off;
  logic        is_mem, misaligned, accept, pass_exc;
  logic [7:0]  wstrb_w;
  logic [63:0] wdata_w;

  assign off        = alu_result[2:0];
  assign is_mem     = mem_ren | mem_wen;
  assign misaligned = ((mem_size == 2'd1) & off[0]) |
                      ((mem_size == 2'd2) & (|off[1:0])) |
                      ((mem_size == 2'd3) & (|off));
  assign accept     = (state_q == IDLE) & ex_valid & is_mem & ~exception_i & ~misaligned;
  assign pass_exc   = exception_i | (is_mem & misaligned);
  assign wstrb_w    = size_mask(mem_size) << off;
  assign wdata_w    = store_data << {off, 3'b000};
  assign stall      = (state_q != IDLE) | accept;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    ctx_d       = ctx_q;
    rdata_d     = rdata_q;
    wb_d        = wb_q;
    wb_d.valid    = 1'b0;
    wb_d.misalign = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ctx_d.is_load = mem_ren & ~mem_wen;
          ctx_d.size    = mem_size;
          ctx_d.ext_un  = mem_ext_un;
          ctx_d.addr    = alu_result;
          ctx_d.rd_wena = rd_wena_i;
          req_d.valid   = 1'b1;
          req_d.wen     = mem_wen;
          req_d.addr    = {alu_result[63:3], 3'b000};
          req_d.wdata   = wdata_w;
          req_d.wstrb   = wstrb_w;
          rdata_d       = '0;
          state_d       = REQ;
        end else if (ex_valid) begin
          // Non-memory, faulting or misaligned: retire straight to WB.
          wb_d.valid       = 1'b1;
          wb_d.alu_result  = alu_result;
          wb_d.mem_data    = '0;
          wb_d.byte_enable = is_mem ? size_mask(mem_size) : 8'h00;
          wb_d.mem_to_reg  = mem_ren & ~mem_wen;
          wb_d.mem_ext_un  = mem_ext_un;
          wb_d.exception   = pass_exc;
          wb_d.rd_wena     = rd_wena_i & ~pass_exc;
          wb_d.misalign    = is_mem & misaligned;
        end
      end
      REQ: begin
        if (bus.req_ready) begin
          req_d.valid = 1'b0;
          state_d     = req_q.wen ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (bus.resp_valid) begin
          rdata_d = bus.resp_rdata >> {ctx_q.addr[2:0], 3'b000};
          state_d = DONE;
        end
      end
      DONE: begin
        wb_d.valid       = 1'b1;
        wb_d.alu_result  = ctx_q.addr;
        wb_d.mem_data    = rdata_q;
        wb_d.byte_enable = size_mask(ctx_q.size);
        wb_d.mem_to_reg  = ctx_q.is_load;
        wb_d.mem_ext_un  = ctx_q.ext_un;
        wb_d.exception   = 1'b0;
        wb_d.rd_wena     = ctx_q.rd_wena;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      ctx_q   <= '0;
      rdata_q <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ctx_q   <= ctx_d;
      rdata_q <= rdata_d;
      wb_q    <= wb_d;
    end
  end

  assign bus.req_valid  = req_q.valid;
  assign bus.req_wen    = req_q.wen;
  assign bus.req_addr   = req_q.addr;
  assign bus.req_wdata  = req_q.wdata;
  assign bus.req_wstrb  = req_q.wstrb;

  assign wb_valid       = wb_q.valid;
  assign wb_alu_result  = wb_q.alu_result;
  assign wb_mem_data    = wb_q.mem_data;
  assign wb_byte_enable = wb_q.byte_enable;
  assign wb_mem_to_reg  = wb_q.mem_to_reg;
  assign wb_mem_ext_un  = wb_q.mem_ext_un;
  assign wb_rd_wena     = wb_q.rd_wena;
  assign wb_exception   = wb_q.exception;
  assign misalign       = wb_q.misalign;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scenario bench for lsu_ctrl: directed cases plus randomized instructions
// scored against a rule-level model of latency, bus request and WB result.
module tb_lsu_ctrl;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        ex_valid, mem_ren, mem_wen, mem_ext_un, rd_wena_i, exception_i;
  logic [1:0]  mem_size;
  logic [63:0] alu_result, store_data;
  logic        wb_valid, wb_mem_to_reg, wb_mem_ext_un, wb_rd_wena, wb_exception;
  logic        stall, misalign;
  logic [63:0] wb_alu_result, wb_mem_data;
  logic [7:0]  wb_byte_enable;

  lsu_ctrl_if bus();

  lsu_ctrl dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .mem_size(mem_size), .mem_ext_un(mem_ext_un),
    .alu_result(alu_result), .store_data(store_data), .rd_wena_i(rd_wena_i),
    .exception_i(exception_i), .bus(bus), .wb_valid(wb_valid),
    .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
    .wb_byte_enable(wb_byte_enable), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_mem_ext_un(wb_mem_ext_un), .wb_rd_wena(wb_rd_wena),
    .wb_exception(wb_exception), .stall(stall), .misalign(misalign)
  );

  int total = 0;
  int bad   = 0;

  // observations of the last do_op
  int          o_lat, o_wbcnt, o_rvcnt, o_hs, o_stallhi, o_stable;
  logic        o_stall0, o_stallwb, o_rwen, o_m2r, o_ext, o_rdw, o_exc, o_mis;
  logic [63:0] o_raddr, o_rwdata, o_alu, o_mem;
  logic [7:0]  o_rwstrb, o_be;

  // reference rules
  function automatic logic [7:0] m_mask(input logic [1:0] sz);
    int n = 1 << sz;
    return (n == 8) ? 8'hFF : 8'((1 << n) - 1);
  endfunction
  function automatic logic m_mis(input logic [1:0] sz, input logic [63:0] a);
    return (a % (64'd1 << sz)) != 0;
  endfunction
  function automatic logic m_acc(input logic r, w, exc, input logic [1:0] sz, input logic [63:0] a);
    return (r | w) & ~exc & ~m_mis(sz, a);
  endfunction

  task automatic do_op(input logic ren, wen, input logic [1:0] sz, input logic ext,
                       input logic [63:0] addr, sd, input logic rdw, exc,
                       input int rdy_dly, resp_dly, input logic [63:0] rdata);
    int resp_at, seen;
    logic acc, ld;
    acc = m_acc(ren, wen, exc, sz, addr);
    ld  = ren & ~wen;
    @(negedge clock);
    ex_valid = 1; mem_ren = ren; mem_wen = wen; mem_size = sz; mem_ext_un = ext;
    alu_result = addr; store_data = sd; rd_wena_i = rdw; exception_i = exc;
    #1 o_stall0 = stall;
    o_lat = -1; o_wbcnt = 0; o_rvcnt = 0; o_hs = 0; o_stallhi = 0; o_stable = 1;
    o_stallwb = 1'bx; resp_at = -1; seen = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clock);
      if (wb_valid) begin
        o_wbcnt++;
        if (o_lat < 0) begin
          o_lat = k; o_stallwb = stall; o_alu = wb_alu_result; o_mem = wb_mem_data;
          o_be = wb_byte_enable; o_m2r = wb_mem_to_reg; o_ext = wb_mem_ext_un;
          o_rdw = wb_rd_wena; o_exc = wb_exception; o_mis = misalign;
        end
      end else if (o_lat < 0 && stall) o_stallhi++;
      if (bus.req_valid) begin
        if (o_rvcnt == 0) begin
          o_raddr = bus.req_addr; o_rwdata = bus.req_wdata;
          o_rwstrb = bus.req_wstrb; o_rwen = bus.req_wen;
        end else if (o_raddr !== bus.req_addr || o_rwdata !== bus.req_wdata ||
                     o_rwstrb !== bus.req_wstrb || o_rwen !== bus.req_wen) o_stable = 0;
        o_rvcnt++;
      end
      // garbage on the EX side while busy must be ignored
      if (k == 1) begin
        ex_valid = acc ? 1'($urandom) : 1'b0;
        mem_ren = 1'($urandom); mem_wen = 1'($urandom); mem_size = 2'($urandom);
        alu_result = {$urandom, $urandom}; store_data = {$urandom, $urandom};
        rd_wena_i = 1'($urandom); exception_i = 1'($urandom);
      end else ex_valid = 0;
      // responses outside WAIT are noise
      if (k == resp_at) begin
        bus.resp_valid = 1; bus.resp_rdata = rdata;
      end else begin
        bus.resp_valid = (resp_at < 0) && ($urandom % 3 == 0);
        bus.resp_rdata = {$urandom, $urandom};
      end
      bus.req_ready = 0;
      if (bus.req_valid) begin
        if (seen >= rdy_dly) begin
          bus.req_ready = 1; o_hs++;
          if (ld) resp_at = k + 1 + resp_dly;
        end
        seen++;
      end
      if (o_lat >= 0 && k >= o_lat + 2) break;
    end
    ex_valid = 0; bus.req_ready = 0; bus.resp_valid = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    #2 reset = 0;
    #1;
    total++; if (stall !== 1'b0 || bus.req_valid !== 1'b0 || wb_valid !== 1'b0 || misalign !== 1'b0)
      begin bad++; $display("FAIL reset_ctl stall=%b req_valid=%b wb_valid=%b misalign=%b want 0", stall, bus.req_valid, wb_valid, misalign); end
    total++; if ({wb_alu_result, wb_mem_data, wb_byte_enable, wb_mem_to_reg, wb_mem_ext_un, wb_rd_wena, wb_exception} !== '0)
      begin bad++; $display("FAIL reset_wb alu=%h mem=%h be=%h want 0", wb_alu_result, wb_mem_data, wb_byte_enable); end
    @(negedge clock); @(negedge clock);
    reset = 1;
  endtask

  task automatic test_nonmem;
    do_op(0, 0, 2'd0, 0, 64'h1234_5678_9ABC_DEF0, 64'h0, 1, 0, 0, 0, 64'h0);
    total++; if (o_lat !== 1) begin bad++; $display("FAIL nonmem_lat got=%0d want=1", o_lat); end
    total++; if (o_alu !== 64'h1234_5678_9ABC_DEF0) begin bad++; $display("FAIL nonmem_alu got=%h want=123456789abcdef0", o_alu); end
    total++; if (o_stall0 !== 1'b0 || o_rvcnt !== 0 || o_rdw !== 1'b1)
      begin bad++; $display("FAIL nonmem_ctl stall=%b req_cycles=%0d rd_wena=%b want 0/0/1", o_stall0, o_rvcnt, o_rdw); end
  endtask

  task automatic test_lb;
    do_op(1, 0, 2'd0, 0, 64'hFFFF_0000_0000_1003, 64'h0, 1, 0, 0, 0, 64'h8877665544332211);
    total++; if (o_raddr !== 64'hFFFF_0000_0000_1000) begin bad++; $display("FAIL lb_addr got=%h want=ffff000000001000", o_raddr); end
    total++; if (o_mem !== 64'h0000_0088_7766_5544) begin bad++; $display("FAIL lb_data got=%h want=0000008877665544", o_mem); end
    total++; if (o_be !== 8'h01 || o_m2r !== 1'b1) begin bad++; $display("FAIL lb_be be=%h m2r=%b want 01/1", o_be, o_m2r); end
    total++; if (o_lat !== 4 || o_stall0 !== 1'b1) begin bad++; $display("FAIL lb_lat got=%0d stall0=%b want 4/1", o_lat, o_stall0); end
  endtask

  task automatic test_sw;
    do_op(0, 1, 2'd2, 0, 64'h0000_0000_0000_2004, 64'hDEADBEEF, 1, 0, 0, 0, 64'h0);
    total++; if (o_rwstrb !== 8'hF0 || o_rwen !== 1'b1) begin bad++; $display("FAIL sw_strb got=%h wen=%b want f0/1", o_rwstrb, o_rwen); end
    total++; if (o_rwdata !== 64'hDEADBEEF_00000000) begin bad++; $display("FAIL sw_wdata got=%h want=deadbeef00000000", o_rwdata); end
    total++; if (o_m2r !== 1'b0 || o_lat !== 3) begin bad++; $display("FAIL sw_wb m2r=%b lat=%0d want 0/3", o_m2r, o_lat); end
  endtask

  task automatic test_both_is_store;
    do_op(1, 1, 2'd3, 0, 64'h80, 64'h1122, 1, 0, 0, 0, 64'h0);
    total++; if (o_rwen !== 1'b1 || o_m2r !== 1'b0 || o_lat !== 3)
      begin bad++; $display("FAIL both_store wen=%b m2r=%b lat=%0d want 1/0/3", o_rwen, o_m2r, o_lat); end
  endtask

  task automatic test_misalign;
    do_op(1, 0, 2'd3, 0, 64'h0000_0000_0000_3002, 64'h0, 1, 0, 0, 0, 64'h0);
    total++; if (o_rvcnt !== 0) begin bad++; $display("FAIL mis_noreq req_cycles=%0d want 0", o_rvcnt); end
    total++; if (o_mis !== 1'b1 || o_exc !== 1'b1 || o_rdw !== 1'b0)
      begin bad++; $display("FAIL mis_flags misalign=%b exc=%b rd_wena=%b want 1/1/0", o_mis, o_exc, o_rdw); end
  endtask

  task automatic test_backpressure;
    do_op(1, 0, 2'd2, 1, 64'h5008, 64'h0, 1, 0, 5, 1, 64'hCAFE_F00D_1234_5678);
    total++; if (o_rvcnt !== 6 || o_stable !== 1 || o_hs !== 1)
      begin bad++; $display("FAIL bp_req req_cycles=%0d stable=%0d handshakes=%0d want 6/1/1", o_rvcnt, o_stable, o_hs); end
    total++; if (o_lat !== 10 || o_stallhi !== 9)
      begin bad++; $display("FAIL bp_stall lat=%0d stall_cycles=%0d want 10/9", o_lat, o_stallhi); end
    total++; if (o_mem !== 64'hCAFE_F00D_1234_5678 || o_ext !== 1'b1)
      begin bad++; $display("FAIL bp_data got=%h ext=%b want cafef00d12345678/1", o_mem, o_ext); end
  endtask

  task automatic test_reset_mid;
    int wbs = 0, stl = 0;
    @(negedge clock);
    ex_valid = 1; mem_ren = 1; mem_wen = 0; mem_size = 2'd3; alu_result = 64'h40;
    exception_i = 0; rd_wena_i = 1;
    @(negedge clock); ex_valid = 0; bus.req_ready = 1;
    @(negedge clock); bus.req_ready = 0;
    #1 reset = 0;
    #1;
    total++; if (stall !== 1'b0 || bus.req_valid !== 1'b0)
      begin bad++; $display("FAIL rst_mid_now stall=%b req_valid=%b want 0/0", stall, bus.req_valid); end
    @(negedge clock); reset = 1; bus.resp_valid = 1; bus.resp_rdata = 64'h5555;
    @(negedge clock); bus.resp_valid = 0;
    for (int k = 0; k < 4; k++) begin
      if (wb_valid) wbs++;
      if (stall) stl++;
      @(negedge clock);
    end
    total++; if (wbs !== 0 || stl !== 0) begin bad++; $display("FAIL rst_mid_after wb_pulses=%0d stall_cycles=%0d want 0/0", wbs, stl); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic ren, wen, ext, rdw, exc, acc, ld, mem, exp_exc;
      logic [1:0] sz; logic [63:0] a, sd, rd;
      int rdy, rsp, off, exp_lat;
      int t = $urandom_range(0, 3);
      ren = (t == 1) || (t == 3); wen = (t >= 2);
      sz = 2'($urandom); ext = 1'($urandom); rdw = 1'($urandom);
      exc = ($urandom % 8 == 0);
      a = {$urandom, $urandom};
      if ($urandom % 2) a = a & ~((64'd1 << sz) - 1);
      sd = {$urandom, $urandom}; rd = {$urandom, $urandom};
      rdy = $urandom_range(0, 3); rsp = $urandom_range(0, 3);
      do_op(ren, wen, sz, ext, a, sd, rdw, exc, rdy, rsp, rd);
      acc = m_acc(ren, wen, exc, sz, a); ld = ren & ~wen; mem = ren | wen;
      off = int'(a % 8);
      exp_lat = !acc ? 1 : (ld ? 4 + rdy + rsp : 3 + rdy);
      exp_exc = exc | (mem & m_mis(sz, a));
      total++; if (o_lat !== exp_lat || o_wbcnt !== 1)
        begin bad++; $display("FAIL rnd%0d_lat got=%0d pulses=%0d want %0d/1", i, o_lat, o_wbcnt, exp_lat); end
      total++; if (o_rvcnt !== (acc ? rdy + 1 : 0) || o_hs !== (acc ? 1 : 0) || o_stable !== 1)
        begin bad++; $display("FAIL rnd%0d_req cycles=%0d hs=%0d stable=%0d want %0d/%0d/1", i, o_rvcnt, o_hs, o_stable, acc ? rdy + 1 : 0, acc ? 1 : 0); end
      if (acc) begin
        total++; if (o_raddr !== (a & ~64'd7) || o_rwstrb !== 8'(m_mask(sz) << off) ||
                     o_rwdata !== (sd << (8 * off)) || o_rwen !== wen)
          begin bad++; $display("FAIL rnd%0d_fields addr=%h strb=%h wdata=%h wen=%b want %h/%h/%h/%b", i, o_raddr, o_rwstrb, o_rwdata, o_rwen,
                               a & ~64'd7, 8'(m_mask(sz) << off), sd << (8 * off), wen); end
      end
      total++; if (o_mem !== ((acc && ld) ? (rd >> (8 * off)) : 64'd0) || o_alu !== a)
        begin bad++; $display("FAIL rnd%0d_wbdata mem=%h alu=%h want %h/%h", i, o_mem, o_alu, (acc && ld) ? (rd >> (8 * off)) : 64'd0, a); end
      total++; if (o_be !== (mem ? m_mask(sz) : 8'h00) || o_m2r !== ld || o_ext !== ext)
        begin bad++; $display("FAIL rnd%0d_wbctl be=%h m2r=%b ext=%b want %h/%b/%b", i, o_be, o_m2r, o_ext, mem ? m_mask(sz) : 8'h00, ld, ext); end
      total++; if (o_exc !== exp_exc || o_rdw !== (rdw & ~exp_exc) || o_mis !== (mem & m_mis(sz, a)))
        begin bad++; $display("FAIL rnd%0d_exc exc=%b rdw=%b mis=%b want %b/%b/%b", i, o_exc, o_rdw, o_mis, exp_exc, rdw & ~exp_exc, mem & m_mis(sz, a)); end
      total++; if (o_stall0 !== acc || o_stallhi !== (acc ? exp_lat - 1 : 0) || o_stallwb !== 1'b0)
        begin bad++; $display("FAIL rnd%0d_stall s0=%b busy=%0d at_wb=%b want %b/%0d/0", i, o_stall0, o_stallhi, o_stallwb, acc, acc ? exp_lat - 1 : 0); end
    end
  endtask

  initial begin
    ex_valid = 0; mem_ren = 0; mem_wen = 0; mem_size = 0; mem_ext_un = 0;
    alu_result = 0; store_data = 0; rd_wena_i = 0; exception_i = 0;
    bus.req_ready = 0; bus.resp_valid = 0; bus.resp_rdata = 0;
    test_reset;
    test_nonmem;
    test_lb;
    test_sw;
    test_both_is_store;
    test_misalign;
    test_backpressure;
    test_reset_mid;
    test_nonmem;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
